multicycle_controller: RTL and testbench

Moore-style control FSM that sequences a shared-resource multicycle RV32I datapath: one ALU, one unified instruction/data memory, one register file. Each instruction takes 3–5 cycles. Per cycle it drives mux selects, write enables and ALU control, replacing the single-cycle control decode. Supports lw, sw, R-type ALU, I-type ALU, beq and jal.

---
 rtl/mc_ctrl_pkg.sv | 32 +++
 rtl/multicycle_controller_alu_decoder.sv | 19 +
 rtl/multicycle_controller.sv | 136 +++++++++++++
 tb/tb_multicycle_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes, ALUOp and select encodings for multicycle_controller
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp plus funct3/op5/funct7b5 to the ALU_control encoding
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);
  always_comb begin
    alu_control = alu_op == ALUOP_SUB   ? ALU_SUB :
                  alu_op != ALUOP_FUNCT ? ALU_ADD :
                  funct3 == 3'b000      ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010      ? ALU_SLT :
                  funct3 == 3'b110      ? ALU_OR  :
                  funct3 == 3'b111      ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RV32I datapath; MC_MEM_WAIT_EN adds mem_ready wait states
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PC_write,
  output logic       Adr_src,
  output logic       Mem_Write,
  output logic       IR_write,
  output logic [1:0] Result_src,
  output logic [1:0] ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [1:0] Imm_src,
  output logic [2:0] ALU_control,
  output logic       Reg_write,
  output logic       instr_done,
  output logic       illegal_op
);
  state_t  state_q, state_d, state_v;
  alu_op_t alu_op;
  logic    rdy, pc_update, branch, ir_write, mem_write, reg_write, done, illegal;
`ifdef MC_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif
  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alu_control(ALU_control)
  );
  always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;
  always_comb begin
    state_v    = rst ? S_FETCH : state_q;
    state_d    = state_v;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    Adr_src    = 1'b0;
    Result_src = RES_ALUOUT;
    ALU_srcA   = SRCA_PC;
    ALU_srcB   = SRCB_REG;
    alu_op     = ALUOP_ADD;
    case (state_v)
      S_FETCH: begin
        ir_write   = rdy;
        pc_update  = rdy;
        ALU_srcB   = SRCB_FOUR;
        Result_src = RES_ALURESULT;
        state_d    = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALU_srcA = SRCA_OLDPC;
        ALU_srcB = SRCB_IMM;
        state_d  = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                   op == OP_R   ? S_EXECR :
                   op == OP_I   ? S_EXECI :
                   op == OP_BEQ ? S_BEQ   :
                   op == OP_JAL ? S_JAL   : S_FETCH;
        illegal  = state_d == S_FETCH;
      end
      S_MEMADR: begin
        ALU_srcA = SRCA_REG;
        ALU_srcB = SRCB_IMM;
        state_d  = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        Adr_src = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        Result_src = RES_DATA;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        Adr_src   = 1'b1;
        mem_write = 1'b1;
        done      = rdy;
        state_d   = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALU_srcA = SRCA_REG;
        alu_op   = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_EXECI: begin
        ALU_srcA = SRCA_REG;
        ALU_srcB = SRCB_IMM;
        alu_op   = ALUOP_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        ALU_srcA = SRCA_REG;
        alu_op   = ALUOP_SUB;
        branch   = 1'b1;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        ALU_srcA  = SRCA_OLDPC;
        ALU_srcB  = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    PC_write   = ~rst & (pc_update | (branch & zero));
    IR_write   = ~rst & ir_write;
    Mem_Write  = ~rst & mem_write;
    Reg_write  = ~rst & reg_write;
    instr_done = ~rst & done;
    illegal_op = ~rst & illegal;
    Imm_src    = op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed pins plus randomized instruction stream against a step-count model
module tb_multicycle_controller;
  localparam logic [6:0] B_LW  = 7'b0000011;
  localparam logic [6:0] B_SW  = 7'b0100011;
  localparam logic [6:0] B_R   = 7'b0110011;
  localparam logic [6:0] B_I   = 7'b0010011;
  localparam logic [6:0] B_BEQ = 7'b1100011;
  localparam logic [6:0] B_JAL = 7'b1101111;
  logic        clk = 1'b0;
  logic        rst, funct7b5, zero, rdy;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        PC_write, Adr_src, Mem_Write, IR_write, Reg_write, instr_done, illegal_op;
  logic [1:0]  Result_src, ALU_srcA, ALU_srcB, Imm_src;
  logic [2:0]  ALU_control;
  logic [17:0] dut_v, e, pin_v;
  logic        pin_en;
  int          pin_no = 0;
  int          k = 0;
  int          errs = 0;
  int          chks = 0;
  always #5 clk = ~clk;
  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
`ifdef MC_MEM_WAIT_EN
    .mem_ready  (rdy),
`endif
    .PC_write   (PC_write),
    .Adr_src    (Adr_src),
    .Mem_Write  (Mem_Write),
    .IR_write   (IR_write),
    .Result_src (Result_src),
    .ALU_srcA   (ALU_srcA),
    .ALU_srcB   (ALU_srcB),
    .Imm_src    (Imm_src),
    .ALU_control(ALU_control),
    .Reg_write  (Reg_write),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );
  assign dut_v = {PC_write, Adr_src, Mem_Write, IR_write, Result_src, ALU_srcA, ALU_srcB,
                  Imm_src, ALU_control, Reg_write, instr_done, illegal_op};
  function automatic logic [17:0] pk(input logic pcw, adr, mw, irw, input logic [1:0] res, a, b, imm,
                                     input logic [2:0] alu, input logic rw, dn, il);
    return {pcw, adr, mw, irw, res, a, b, imm, alu, rw, dn, il};
  endfunction
  function automatic int len(input logic [6:0] o);
    return o == B_LW ? 5 : o == B_BEQ ? 3 : o inside {B_SW, B_R, B_I, B_JAL} ? 4 : 2;
  endfunction
  function automatic logic waits(input logic [6:0] o, input int s);
    return s == 0 || (s == 3 && (o == B_LW || o == B_SW));
  endfunction
  function automatic logic [17:0] model(input logic [6:0] o, input int s, input logic [2:0] f,
                                        input logic b7, z, rd, r);
    logic       pcw, adr, mw, irw, rw, dn, il;
    logic [1:0] res, a, b, imm;
    logic [2:0] alu, fn;
    {pcw, adr, mw, irw, rw, dn, il} = '0;
    {res, a, b, alu} = '0;
    imm = o == B_SW ? 2'd1 : o == B_BEQ ? 2'd2 : o == B_JAL ? 2'd3 : 2'd0;
    fn  = f == 3'd0 ? ((o == B_R && b7) ? 3'b001 : 3'b000) : f == 3'd2 ? 3'b101 :
          f == 3'd6 ? 3'b011 : f == 3'd7 ? 3'b010 : 3'b000;
    if (r || s == 0) begin
      res = 2'd2;
      b   = 2'd2;
      pcw = !r && rd;
      irw = !r && rd;
    end else if (s == 1) begin
      a  = 2'd1;
      b  = 2'd1;
      il = len(o) == 2;
    end else if (s == 2) begin
      a   = (o == B_JAL) ? 2'd1 : 2'd2;
      b   = (o == B_JAL) ? 2'd2 : (o == B_R || o == B_BEQ) ? 2'd0 : 2'd1;
      alu = (o == B_R || o == B_I) ? fn : (o == B_BEQ) ? 3'b001 : 3'b000;
      pcw = (o == B_JAL) || (o == B_BEQ && z);
      dn  = o == B_BEQ;
    end else if (s == 3 && (o == B_LW || o == B_SW)) begin
      adr = 1'b1;
      mw  = o == B_SW;
      dn  = o == B_SW && rd;
    end else begin
      res = (o == B_LW) ? 2'd1 : 2'd0;
      rw  = 1'b1;
      dn  = 1'b1;
    end
    return {pcw, adr, mw, irw, res, a, b, imm, alu, rw, dn, il};
  endfunction
  always @(negedge clk) begin
    e = model(op, k, funct3, funct7b5, zero, rdy, rst);
    chks++;
    if (dut_v !== e) begin
      errs++;
      $display("FAIL model op=%b step=%0d rst=%b got=%b want=%b", op, k, rst, dut_v, e);
    end
    if (pin_en) begin
      chks++;
      if (dut_v !== pin_v) begin
        errs++;
        $display("FAIL pin#%0d op=%b got=%b want=%b", pin_no, op, dut_v, pin_v);
      end
    end
    k = rst ? 0 : (waits(op, k) && !rdy) ? k : (k + 1 == len(op)) ? 0 : k + 1;
  end
  task automatic tick(input logic r, input logic [6:0] o, input logic [2:0] f, input logic b7, z, rd,
                      input logic [17:0] want);
    @(posedge clk);
    #1;
    rst = r; op = o; funct3 = f; funct7b5 = b7; zero = z; rdy = rd;
    pin_v = want; pin_en = 1'b1; pin_no++;
  endtask
  initial begin
    rst = 1'b1; op = B_R; funct3 = 3'd0; funct7b5 = 1'b1; zero = 1'b0; rdy = 1'b1;
    pin_en = 1'b0; pin_v = '0;
    repeat (3) tick(1, B_R, 0, 1, 0, 1, pk(0,0,0,0,2,0,2,0,0,0,0,0));
    tick(0, B_R, 0, 1, 0, 1, pk(1,0,0,1,2,0,2,0,0,0,0,0));
    tick(0, B_R, 0, 1, 0, 1, pk(0,0,0,0,0,1,1,0,0,0,0,0));
    tick(0, B_R, 0, 1, 0, 1, pk(0,0,0,0,0,2,0,0,1,0,0,0));
    tick(0, B_R, 0, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,1,1,0));
    tick(0, B_LW, 2, 1, 0, 1, pk(1,0,0,1,2,0,2,0,0,0,0,0));
    tick(0, B_LW, 2, 1, 0, 1, pk(0,0,0,0,0,1,1,0,0,0,0,0));
    tick(0, B_LW, 2, 1, 0, 1, pk(0,0,0,0,0,2,1,0,0,0,0,0));
    tick(0, B_LW, 2, 1, 0, 1, pk(0,1,0,0,0,0,0,0,0,0,0,0));
    tick(0, B_LW, 2, 1, 0, 1, pk(0,0,0,0,1,0,0,0,0,1,1,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(1,0,0,1,2,0,2,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(0,0,0,0,0,1,1,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(0,0,0,0,0,2,1,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(0,1,1,0,0,0,0,1,0,0,1,0));
    tick(0, B_BEQ, 0, 0, 1, 1, pk(1,0,0,1,2,0,2,2,0,0,0,0));
    tick(0, B_BEQ, 0, 0, 1, 1, pk(0,0,0,0,0,1,1,2,0,0,0,0));
    tick(0, B_BEQ, 0, 0, 1, 1, pk(1,0,0,0,0,2,0,2,1,0,1,0));
    tick(0, B_BEQ, 0, 0, 0, 1, pk(1,0,0,1,2,0,2,2,0,0,0,0));
    tick(0, B_BEQ, 0, 0, 0, 1, pk(0,0,0,0,0,1,1,2,0,0,0,0));
    tick(0, B_BEQ, 0, 0, 0, 1, pk(0,0,0,0,0,2,0,2,1,0,1,0));
    tick(0, B_JAL, 0, 0, 0, 1, pk(1,0,0,1,2,0,2,3,0,0,0,0));
    tick(0, B_JAL, 0, 0, 0, 1, pk(0,0,0,0,0,1,1,3,0,0,0,0));
    tick(0, B_JAL, 0, 0, 0, 1, pk(1,0,0,0,0,1,2,3,0,0,0,0));
    tick(0, B_JAL, 0, 0, 0, 1, pk(0,0,0,0,0,0,0,3,0,1,1,0));
    tick(0, 7'h7f, 0, 0, 0, 1, pk(1,0,0,1,2,0,2,0,0,0,0,0));
    tick(0, 7'h7f, 0, 0, 0, 1, pk(0,0,0,0,0,1,1,0,0,0,0,1));
    tick(0, B_I, 0, 1, 0, 1, pk(1,0,0,1,2,0,2,0,0,0,0,0));
    tick(0, B_I, 0, 1, 0, 1, pk(0,0,0,0,0,1,1,0,0,0,0,0));
    tick(0, B_I, 0, 1, 0, 1, pk(0,0,0,0,0,2,1,0,0,0,0,0));
    tick(0, B_I, 0, 1, 0, 1, pk(0,0,0,0,0,0,0,0,0,1,1,0));
    tick(0, B_R, 2, 0, 0, 1, pk(1,0,0,1,2,0,2,0,0,0,0,0));
    tick(0, B_R, 2, 0, 0, 1, pk(0,0,0,0,0,1,1,0,0,0,0,0));
    tick(0, B_R, 2, 0, 0, 1, pk(0,0,0,0,0,2,0,0,5,0,0,0));
    tick(0, B_R, 2, 0, 0, 1, pk(0,0,0,0,0,0,0,0,0,1,1,0));
`ifdef MC_MEM_WAIT_EN
    repeat (3) tick(0, B_SW, 2, 0, 0, 0, pk(0,0,0,0,2,0,2,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(1,0,0,1,2,0,2,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(0,0,0,0,0,1,1,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(0,0,0,0,0,2,1,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 0, pk(0,1,1,0,0,0,0,1,0,0,0,0));
    tick(1, B_SW, 2, 0, 0, 0, pk(0,0,0,0,2,0,2,1,0,0,0,0));
    tick(0, B_SW, 2, 0, 0, 1, pk(1,0,0,1,2,0,2,1,0,0,0,0));
`endif
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      pin_en = 1'b0;
      rst    = $urandom_range(0, 49) == 0;
      zero   = 1'($urandom);
`ifdef MC_MEM_WAIT_EN
      rdy    = $urandom_range(0, 3) != 0;
`else
      rdy    = 1'b1;
`endif
      if (k == 0) begin
        case ($urandom_range(0, 6))
          0: op = B_LW;
          1: op = B_SW;
          2: op = B_R;
          3: op = B_I;
          4: op = B_BEQ;
          5: op = B_JAL;
          default: op = 7'($urandom);
        endcase
        funct3   = 3'($urandom);
        funct7b5 = 1'($urandom);
      end
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
